spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Round-robin arbiter and sequencer that shares one `spi_controller` between `NUM_REQ` requesters. It latches a winner's transfer word and bit widths, and drives the controller's KICK edge protocol. It then tracks BUSY and DOUT_VALID through the end of the transfer and returns the read data to the granted requester. It sits between the register/AXI-side clients and the single SPI controller. Timing configuration (SCLK_HALF_PERIOD, CS_DELAY, DATA_DELAY, CPOL, CPHA) stays wired directly to the controller.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 100000, watchdog limit in CLK cycles (used only with SPI_ARB_TIMEOUT_EN)
- Clocking: one clock; reset is asynchronous and active-low.
- CLK  in  1  clock
- RESET_N  in  1  asynchronous, active-low reset
- REQ  in  NUM_REQ  request levels; held with payload stable until own RSP_VALID
- REQ_DIN  in  32*NUM_REQ  per-requester MOSI word, slice i = [32*i+31:32*i]
- REQ_MOSI_WIDTH  in  8*NUM_REQ  MOSI bit count, legal 1..32
- REQ_MISO_WIDTH  in  8*NUM_REQ  MISO bit count, legal 1..32
- GNT  out  NUM_REQ  one-hot grant
- RSP_VALID  out  NUM_REQ  one-cycle response pulse per requester
- RSP_DOUT  out  32  read data, valid with RSP_VALID, held until next response
- RSP_ERR  out  1  error flag, valid with RSP_VALID
- SPI_KICK  out  1  to controller KICK
- SPI_DIN  out  32  to controller DIN
- SPI_MOSI_WIDTH  out  8  to controller MOSI_WIDTH
- SPI_MISO_WIDTH  out  8  to controller MISO_WIDTH
- SPI_SEL  out  $clog2(NUM_REQ)  granted index, routes controller CS to a device
- SPI_ABORT  out  1  one-cycle pulse, OR'd into controller RESET
- SPI_BUSY  in  1  from controller BUSY
- SPI_DOUT  in  32  from controller DOUT
- SPI_DOUT_VALID  in  1  from controller DOUT_VALID

## Operation
- States: IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE, WAIT_IDLE.
- **IDLE:** if any REQ is set, pick a winner round-robin starting at last_grant+1 (mod NUM_REQ).
  - Register GNT, SPI_SEL, SPI_DIN and the widths.
  - Go to LOAD.
- **Width check in IDLE:** if either of the winner's widths is 0 or >32, do not kick.
  - Next cycle: RSP_VALID[i]=1, RSP_ERR=1, RSP_DOUT=0.
  - GNT cleared, last_grant updated, state stays IDLE.
- **LOAD:** SPI_KICK=0 for one cycle. This guarantees a rising edge, because the controller samples KICK against its registered copy. → KICK.
- **KICK:** SPI_KICK=1 for exactly one cycle. → WAIT_BUSY.
- **WAIT_BUSY:** wait for SPI_BUSY=1, then → WAIT_DONE.
- **WAIT_DONE:** on SPI_DOUT_VALID=1:
  - Register RSP_DOUT=SPI_DOUT, RSP_ERR=0, RSP_VALID[sel]=1 for one cycle.
  - Clear GNT, set last_grant=sel, → WAIT_IDLE.
- **WAIT_IDLE:** wait for SPI_BUSY=0, then → IDLE. The controller's POST_DATA/POST_CS phases complete here.
- REQ still high after its RSP_VALID counts as a new request and is re-arbitrated with rotated priority.
- REQ dropping while granted is ignored; the transfer completes and RSP_VALID still pulses.
- SPI_DIN and the width outputs hold their values from IDLE through WAIT_IDLE.

## Timing
- Reset values:
  - GNT=0, RSP_VALID=0, RSP_DOUT=0, RSP_ERR=0.
  - SPI_KICK=0, SPI_DIN=0, SPI_MOSI_WIDTH=0, SPI_MISO_WIDTH=0, SPI_SEL=0, SPI_ABORT=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first. State=IDLE.
- REQ sampled high at edge t: GNT at t+1 (LOAD), SPI_KICK high in cycle t+2, controller BUSY expected from t+3.
- RSP_VALID rises the cycle after SPI_DOUT_VALID is sampled high. GNT falls in that same cycle.
- Minimum gap between two transfers: WAIT_IDLE, then one IDLE cycle, then LOAD.
- Reset mid-transfer: all outputs return to reset values asynchronously. The controller is reset by its own domain logic.

## Configuration
- SPI_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering KICK and counts in WAIT_BUSY, WAIT_DONE and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES in WAIT_BUSY or WAIT_DONE: SPI_ABORT=1 for one cycle, RSP_VALID[sel]=1 with RSP_ERR=1 and RSP_DOUT=0, GNT cleared, → IDLE.
  - Reaching TIMEOUT_CYCLES in WAIT_IDLE: SPI_ABORT pulses, no response, → IDLE.
- SPI_ARB_TIMEOUT_EN undefined: no counter, SPI_ABORT tied 0, RSP_ERR is set only by the width check.

## Structure
- Package spi_arb_pkg holds the state enum, MAX_WIDTH=32, and the reset value of SPI_SEL.
- Sub-module spi_arb_rr_picker: combinational round-robin pick.
  - Inputs: REQ vector and last_grant.
  - Outputs: found flag and winner index.

## Test plan
- Single request: REQ[0]=1, DIN=0xA5000000, MOSI=8, MISO=8, slave returns 0x3C.
  - Expect one SPI_KICK pulse 2 cycles after REQ and SPI_SEL=0.
  - Expect RSP_VALID[0] with RSP_DOUT=0x0000003C, RSP_ERR=0.
- Fairness: REQ=4'b1111 held for 8 transfers. Expect grant order 0,1,2,3,0,1,2,3 and no SPI_KICK while SPI_BUSY=1.
- Illegal width: REQ[2] with MISO_WIDTH=0. Expect RSP_VALID[2] with RSP_ERR=1, no SPI_KICK, and REQ[3] served next.
- Reset mid-transfer: assert RESET_N=0 during WAIT_DONE. Expect all outputs at reset values immediately and requester 0 granted first after release.
- Timeout (macro on, TIMEOUT_CYCLES=50, SPI_BUSY stuck 0):
  - Expect SPI_ABORT pulse 50 cycles after KICK.
  - Expect RSP_VALID with RSP_ERR=1, RSP_DOUT=0.
  - Expect a following request to be served normally.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI arbiter.
package spi_arb_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned SEL_RST   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_WAIT_IDLE
    } arb_state_e;

    // A bit count is legal when it is between 1 and MAX_WIDTH.
    function automatic logic width_ok(input logic [7:0] w);
        return (w != 8'd0) && (32'(w) <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/spi_arb_rr_picker.sv
// Combinational round-robin pick: first requester after last_i, wrapping.
module spi_arb_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   last_i,
    output logic               found_o,
    output logic [SEL_W-1:0]   idx_o
);

    function automatic int unsigned wrap(input int unsigned v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // Scan last_i+1 .. last_i+NUM_REQ; the first set bit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!found_o && req_i[SEL_W'(wrap(32'(last_i) + i))]) begin
                found_o = 1'b1;
                idx_o   = SEL_W'(wrap(32'(last_i) + i));
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI controller between NUM_REQ
// requesters. Optional watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [32*NUM_REQ-1:0]      req_din_i,
    input  logic [8*NUM_REQ-1:0]       req_mosi_width_i,
    input  logic [8*NUM_REQ-1:0]       req_miso_width_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic [31:0]                rsp_dout_o,
    output logic                       rsp_err_o,
    output logic                       spi_kick_o,
    output logic [31:0]                spi_din_o,
    output logic [7:0]                 spi_mosi_width_o,
    output logic [7:0]                 spi_miso_width_o,
    output logic [$clog2(NUM_REQ)-1:0] spi_sel_o,
    output logic                       spi_abort_o,
    input  logic                       spi_busy_i,
    input  logic [31:0]                spi_dout_i,
    input  logic                       spi_dout_valid_i
);

    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_dout_q, rsp_dout_d;
    logic                rsp_err_q, rsp_err_d;
    logic                kick_q, kick_d;
    logic [31:0]         din_q, din_d;
    logic [7:0]          mosi_w_q, mosi_w_d;
    logic [7:0]          miso_w_q, miso_w_d;
    logic [SEL_W-1:0]    sel_q, sel_d;

    logic                found;
    logic [SEL_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  req_eff;
    logic [31:0]         win_din;
    logic [7:0]          win_mosi_w;
    logic [7:0]          win_miso_w;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
`endif

    // A requester whose response is on the wire this cycle is not re-picked yet.
    assign req_eff    = req_i & ~rsp_valid_q;
    assign win_din    = req_din_i[32'(win_idx)*32 +: 32];
    assign win_mosi_w = req_mosi_width_i[32'(win_idx)*8 +: 8];
    assign win_miso_w = req_miso_width_i[32'(win_idx)*8 +: 8];

    spi_arb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_picker (
        .req_i   (req_eff),
        .last_i  (last_q),
        .found_o (found),
        .idx_o   (win_idx)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_dout_d  = rsp_dout_q;
        rsp_err_d   = rsp_err_q;
        kick_d      = 1'b0;
        din_d       = din_q;
        mosi_w_d    = mosi_w_q;
        miso_w_d    = miso_w_q;
        sel_d       = sel_q;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        abort_d     = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    if (width_ok(win_mosi_w) && width_ok(win_miso_w)) begin
                        gnt_d          = '0;
                        gnt_d[win_idx] = 1'b1;
                        sel_d          = win_idx;
                        din_d          = win_din;
                        mosi_w_d       = win_mosi_w;
                        miso_w_d       = win_miso_w;
                        state_d        = ST_LOAD;
                    end else begin
                        rsp_valid_d[win_idx] = 1'b1;
                        rsp_err_d            = 1'b1;
                        rsp_dout_d           = '0;
                        last_d               = win_idx;
                    end
                end
            end
            ST_LOAD: begin
                kick_d  = 1'b1;
                state_d = ST_KICK;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_KICK: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy_i) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (spi_dout_valid_i) begin
                    rsp_valid_d[sel_q] = 1'b1;
                    rsp_dout_d         = spi_dout_i;
                    rsp_err_d          = 1'b0;
                    gnt_d              = '0;
                    last_d             = sel_q;
                    state_d            = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!spi_busy_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog window starts at the KICK cycle; expiry overrides normal flow.
        if (state_q inside {ST_KICK, ST_WAIT_BUSY, ST_WAIT_DONE, ST_WAIT_IDLE}) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q != ST_KICK && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                abort_d = 1'b1;
                gnt_d   = '0;
                state_d = ST_IDLE;
                if (state_q != ST_WAIT_IDLE) begin
                    rsp_valid_d        = '0;
                    rsp_valid_d[sel_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    rsp_dout_d         = '0;
                    last_d             = sel_q;
                end
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= SEL_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_dout_q  <= '0;
            rsp_err_q   <= 1'b0;
            kick_q      <= 1'b0;
            din_q       <= '0;
            mosi_w_q    <= '0;
            miso_w_q    <= '0;
            sel_q       <= SEL_W'(SEL_RST);
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dout_q  <= rsp_dout_d;
            rsp_err_q   <= rsp_err_d;
            kick_q      <= kick_d;
            din_q       <= din_d;
            mosi_w_q    <= mosi_w_d;
            miso_w_q    <= miso_w_d;
            sel_q       <= sel_d;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
`endif
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    assign spi_abort_o = abort_q;
`else
    assign spi_abort_o = 1'b0;
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign gnt_o            = gnt_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_dout_o       = rsp_dout_q;
    assign rsp_err_o        = rsp_err_q;
    assign spi_kick_o       = kick_q;
    assign spi_din_o        = din_q;
    assign spi_mosi_width_o = mosi_w_q;
    assign spi_miso_width_o = miso_w_q;
    assign spi_sel_o        = sel_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a hand-driven SPI controller model.
module tb_spi_arbiter;

    localparam int unsigned N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_i;
    logic [32*N-1:0] req_din_i;
    logic [8*N-1:0]  req_mosi_width_i;
    logic [8*N-1:0]  req_miso_width_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rsp_valid_o;
    logic [31:0]     rsp_dout_o;
    logic            rsp_err_o;
    logic            spi_kick_o;
    logic [31:0]     spi_din_o;
    logic [7:0]      spi_mosi_width_o;
    logic [7:0]      spi_miso_width_o;
    logic [1:0]      spi_sel_o;
    logic            spi_abort_o;
    logic            spi_busy_i;
    logic [31:0]     spi_dout_i;
    logic            spi_dout_valid_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] din_tab [N];

    spi_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req_i),
        .req_din_i        (req_din_i),
        .req_mosi_width_i (req_mosi_width_i),
        .req_miso_width_i (req_miso_width_i),
        .gnt_o            (gnt_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_dout_o       (rsp_dout_o),
        .rsp_err_o        (rsp_err_o),
        .spi_kick_o       (spi_kick_o),
        .spi_din_o        (spi_din_o),
        .spi_mosi_width_o (spi_mosi_width_o),
        .spi_miso_width_o (spi_miso_width_o),
        .spi_sel_o        (spi_sel_o),
        .spi_abort_o      (spi_abort_o),
        .spi_busy_i       (spi_busy_i),
        .spi_dout_i       (spi_dout_i),
        .spi_dout_valid_i (spi_dout_valid_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_gnt",    32'(gnt_o), 32'd0);
        check_eq("rst_rspv",   32'(rsp_valid_o), 32'd0);
        check_eq("rst_dout",   rsp_dout_o, 32'd0);
        check_eq("rst_err",    32'(rsp_err_o), 32'd0);
        check_eq("rst_kick",   32'(spi_kick_o), 32'd0);
        check_eq("rst_din",    spi_din_o, 32'd0);
        check_eq("rst_mosiw",  32'(spi_mosi_width_o), 32'd0);
        check_eq("rst_misow",  32'(spi_miso_width_o), 32'd0);
        check_eq("rst_sel",    32'(spi_sel_o), 32'd0);
        check_eq("rst_abort",  32'(spi_abort_o), 32'd0);
    endtask

    // One complete transfer for requester idx, starting in IDLE or LOAD.
    task automatic do_xfer(input int idx, input logic [31:0] rdata, input logic drop_req);
        int n;
        n = 0;
        while (spi_kick_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("kick_seen", 32'(n < 20), 32'd1);
        check_eq("sel",   32'(spi_sel_o), 32'(idx));
        check_eq("gnt",   32'(gnt_o), 32'd1 << idx);
        check_eq("din",   spi_din_o, din_tab[idx]);
        check_eq("mosiw", 32'(spi_mosi_width_o), 32'(8 * (idx + 1)));
        check_eq("misow", 32'(spi_miso_width_o), 32'd8);
        tick();
        check_eq("kick_1cyc", 32'(spi_kick_o), 32'd0);
        spi_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("kick_busy", 32'(spi_kick_o), 32'd0);
            check_eq("rspv_early", 32'(rsp_valid_o), 32'd0);
        end
        spi_dout_i       = rdata;
        spi_dout_valid_i = 1'b1;
        tick();
        spi_dout_valid_i = 1'b0;
        check_eq("rspv",     32'(rsp_valid_o), 32'd1 << idx);
        check_eq("rsp_dout", rsp_dout_o, rdata);
        check_eq("rsp_err",  32'(rsp_err_o), 32'd0);
        check_eq("gnt_fall", 32'(gnt_o), 32'd0);
        if (drop_req) req_i[idx] = 1'b0;
        tick();
        check_eq("rspv_pulse", 32'(rsp_valid_o), 32'd0);
        check_eq("dout_hold",  rsp_dout_o, rdata);
        check_eq("kick_widle", 32'(spi_kick_o), 32'd0);
        spi_busy_i = 1'b0;
        tick();
    endtask

    initial begin
        din_tab[0] = 32'hA500_0000;
        din_tab[1] = 32'h1111_1111;
        din_tab[2] = 32'h2222_2222;
        din_tab[3] = 32'h3333_3333;
        rst_n = 1'b0;
        req_i = '0;
        for (int i = 0; i < N; i++) begin
            req_din_i[32*i +: 32]       = din_tab[i];
            req_mosi_width_i[8*i +: 8]  = 8'(8 * (i + 1));
            req_miso_width_i[8*i +: 8]  = 8'd8;
        end
        spi_busy_i       = 1'b0;
        spi_dout_i       = '0;
        spi_dout_valid_i = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // Single request: GNT one cycle after REQ, KICK the cycle after
        req_i = 4'b0001;
        tick();
        check_eq("t1_gnt",  32'(gnt_o), 32'd1);
        check_eq("t1_kick0", 32'(spi_kick_o), 32'd0);
        tick();
        check_eq("t1_kick1", 32'(spi_kick_o), 32'd1);
        do_xfer(0, 32'h0000_003C, 1'b1);

        // Illegal MISO width on requester 2, requester 3 also waiting
        req_miso_width_i[8*2 +: 8] = 8'd0;
        req_i = 4'b1100;
        tick();
        check_eq("ill_rspv", 32'(rsp_valid_o), 32'b0100);
        check_eq("ill_err",  32'(rsp_err_o), 32'd1);
        check_eq("ill_dout", rsp_dout_o, 32'd0);
        check_eq("ill_gnt",  32'(gnt_o), 32'd0);
        check_eq("ill_kick", 32'(spi_kick_o), 32'd0);
        req_i[2] = 1'b0;
        req_miso_width_i[8*2 +: 8] = 8'd8;
        do_xfer(3, 32'hBEEF_0003, 1'b1);

        // Fairness: all four held, priority rotates after each response
        req_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            do_xfer(k % 4, 32'hC0DE_0000 | 32'(k), 1'b0);
        end
        req_i = '0;

        // Reset mid-transfer: last_grant must return to NUM_REQ-1
        req_i = 4'b0001;
        do_xfer(0, 32'h0000_0055, 1'b1);
        req_i = 4'b0011;
        tick();
        tick();
        check_eq("mid_kick", 32'(spi_kick_o), 32'd1);
        check_eq("mid_sel",  32'(spi_sel_o), 32'd1);
        tick();
        spi_busy_i = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        spi_busy_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_gnt", 32'(gnt_o), 32'd1);
        do_xfer(0, 32'h0000_0077, 1'b1);
        req_i = '0;
        tick();
        check_eq("idle_gnt", 32'(gnt_o), 32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: controller never raises BUSY
        begin
            int n;
            req_i = 4'b0001;
            n = 0;
            while (spi_kick_o !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check_eq("to_kick", 32'(n < 20), 32'd1);
            n = 0;
            while (spi_abort_o !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            check_eq("to_delay", 32'(n), 32'd50);
            check_eq("to_rspv",  32'(rsp_valid_o), 32'd1);
            check_eq("to_err",   32'(rsp_err_o), 32'd1);
            check_eq("to_dout",  rsp_dout_o, 32'd0);
            check_eq("to_gnt",   32'(gnt_o), 32'd0);
            req_i = '0;
            tick();
            check_eq("to_abort1", 32'(spi_abort_o), 32'd0);
            req_i = 4'b0010;
            do_xfer(1, 32'h0000_0099, 1'b1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
